// File: rtl/mem_pkg.sv
// Shared encodings, widths and the memory-port payload for the memory-stage LSU.
package mem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OFF_W = 2;
  localparam int unsigned WEB_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LB   = 3'b001,
    LD_LH   = 3'b010,
    LD_LW   = 3'b011,
    LD_LBU  = 3'b100,
    LD_LHU  = 3'b101
  } ld_type_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SB   = 2'b01,
    ST_SH   = 2'b10,
    ST_SW   = 2'b11
  } st_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [WEB_W-1:0] web;
    logic [XLEN-1:0]  wdata;
  } dm_cmd_t;

endpackage

// File: rtl/lsu_align.sv
// Decodes access size, builds byte-lane enables and replicated store data,
// flags misalignment and right-justifies the returned read word.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]       is_load,
  input  logic [1:0]       is_store,
  input  logic [OFF_W-1:0] req_off,
  input  logic [XLEN-1:0]  st_data,
  input  logic [OFF_W-1:0] rd_off,
  input  logic [XLEN-1:0]  rd_word,
  output logic             ld_c,
  output logic             st_c,
  output logic             misalign_c,
  output logic [WEB_W-1:0] web_c,
  output logic [XLEN-1:0]  wdata_c,
  output logic [XLEN-1:0]  rdata_c
);

  logic half_c;
  logic word_c;

  always_comb begin
    ld_c    = 1'b0;
    st_c    = 1'b0;
    half_c  = 1'b0;
    word_c  = 1'b0;
    web_c   = '0;
    wdata_c = st_data;

    case (is_load)
      LD_LB, LD_LBU: ld_c = 1'b1;
      LD_LH, LD_LHU: begin
        ld_c   = 1'b1;
        half_c = 1'b1;
      end
      LD_LW: begin
        ld_c   = 1'b1;
        word_c = 1'b1;
      end
      default: ;
    endcase

    // A load wins over a simultaneously flagged store.
    if (!ld_c) begin
      case (is_store)
        ST_SB: begin
          st_c    = 1'b1;
          web_c   = WEB_W'(4'b0001 << req_off);
          wdata_c = {4{st_data[7:0]}};
        end
        ST_SH: begin
          st_c    = 1'b1;
          half_c  = 1'b1;
          web_c   = WEB_W'(4'b0011 << req_off);
          wdata_c = {2{st_data[15:0]}};
        end
        ST_SW: begin
          st_c   = 1'b1;
          word_c = 1'b1;
          web_c  = '1;
        end
        ST_NONE: ;
        default: ;
      endcase
    end

    misalign_c = (half_c && req_off[0]) || (word_c && (req_off != '0));
    rdata_c    = rd_word >> {rd_off, 3'b000};
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one request/ready access per instruction,
// stalls the pipeline until it completes or times out, then presents DM_OUT.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [2:0]       is_load_mem,
  input  logic [1:0]       is_store_mem,
  input  logic [XLEN-1:0]  alu_out_mem,
  input  logic [XLEN-1:0]  rs2_data_mem,
  output logic             dm_req,
  output logic [WEB_W-1:0] dm_web,
  output logic [XLEN-1:0]  dm_addr,
  output logic [XLEN-1:0]  dm_wdata,
  input  logic             dm_ready,
  input  logic [XLEN-1:0]  dm_rdata,
  output logic [XLEN-1:0]  DM_OUT,
  output logic             mem_stall,
  output logic             misalign_err,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  dm_cmd_t           cmd_q, cmd_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic              ld_q, ld_d;
  logic [OFF_W-1:0]  off_q, off_d;

  logic              ld_c, st_c, misalign_c;
  logic [WEB_W-1:0]  web_c;
  logic [XLEN-1:0]   wdata_c, rdata_c;
  logic              access_c;

  lsu_align u_align (
    .is_load    (is_load_mem),
    .is_store   (is_store_mem),
    .req_off    (alu_out_mem[OFF_W-1:0]),
    .st_data    (rs2_data_mem),
    .rd_off     (off_q),
    .rd_word    (dm_rdata),
    .ld_c       (ld_c),
    .st_c       (st_c),
    .misalign_c (misalign_c),
    .web_c      (web_c),
    .wdata_c    (wdata_c),
    .rdata_c    (rdata_c)
  );

  assign access_c = mem_valid && (ld_c || st_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      req_q   <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      ld_q    <= 1'b0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      req_q   <= req_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ld_q    <= ld_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    req_d        = req_q;
    out_d        = out_q;
    cnt_d        = cnt_q;
    tmo_d        = 1'b0;
    ld_d         = ld_q;
    off_d        = off_q;
    mem_stall    = 1'b0;
    misalign_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (access_c) begin
          if (misalign_c) begin
            misalign_err = 1'b1;
          end else begin
            mem_stall   = 1'b1;
            state_d     = BUSY;
            req_d       = 1'b1;
            cmd_d.addr  = {alu_out_mem[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            cmd_d.web   = web_c;
            cmd_d.wdata = wdata_c;
            cnt_d       = '0;
            ld_d        = ld_c;
            off_d       = alu_out_mem[OFF_W-1:0];
          end
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        // A response on the last allowed cycle still completes the access.
        if (dm_ready) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (ld_q) out_d = rdata_c;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          out_d   = '0;
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dm_req      = req_q;
  assign dm_web      = cmd_q.web;
  assign dm_addr     = cmd_q.addr;
  assign dm_wdata    = cmd_q.wdata;
  assign DM_OUT      = out_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized scoreboard bench for mem_lsu with a byte-addressed reference memory.
module tb_mem_lsu;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [2:0]  is_load_mem;
  logic [1:0]  is_store_mem;
  logic [31:0] alu_out_mem;
  logic [31:0] rs2_data_mem;
  logic        dm_req;
  logic [3:0]  dm_web;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic [31:0] DM_OUT;
  logic        mem_stall;
  logic        misalign_err;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .is_load_mem  (is_load_mem),
    .is_store_mem (is_store_mem),
    .alu_out_mem  (alu_out_mem),
    .rs2_data_mem (rs2_data_mem),
    .dm_req       (dm_req),
    .dm_web       (dm_web),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_ready     (dm_ready),
    .dm_rdata     (dm_rdata),
    .DM_OUT       (DM_OUT),
    .mem_stall    (mem_stall),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    bit          misal;
    bit          tmo;
    bit          is_st;
    int          stall;
    logic [31:0] out;
    logic [31:0] addr;
    logic [3:0]  web;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          lat_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem[64];
  logic [31:0] dev_mem[16];
  logic [31:0] last_out;
  bit          mon_en = 1'b0;
  bit          mem_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Memory device: answers each request after a latency chosen by the driver.
  initial begin : mem_model
    int  wait_c;
    int  lat;
    bit  active;
    int  idx;
    active = 1'b0;
    wait_c = 0;
    lat    = 0;
    dm_ready = 1'b0;
    dm_rdata = '0;
    forever begin
      @(negedge clk);
      dm_ready = 1'b0;
      dm_rdata = $urandom();
      if (mem_en && dm_req) begin
        if (!active) begin
          active = 1'b1;
          wait_c = 0;
          if (lat_q.size() > 0) lat = lat_q.pop_front();
          else begin
            lat = 0;
            fail("unexpected_request");
          end
        end
        if (wait_c == lat) begin
          dm_ready = 1'b1;
          active   = 1'b0;
          idx      = int'(dm_addr[5:2]);
          for (int b = 0; b < 4; b++)
            if (dm_web[b]) dev_mem[idx][8*b +: 8] = dm_wdata[8*b +: 8];
          dm_rdata = dev_mem[idx];
        end
        wait_c++;
      end else begin
        active = 1'b0;
        if (mem_en) dm_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops the scoreboard on misalign pulses and on the DONE cycle.
  initial begin : monitor
    int   stall_cnt;
    bit   req_prev;
    exp_t e;
    stall_cnt = 0;
    req_prev  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) begin
        stall_cnt = 0;
        req_prev  = 1'b0;
      end else begin
        if (misalign_err) begin
          if (exp_q.size() == 0) fail("misalign_unexpected");
          else begin
            e = exp_q.pop_front();
            chk("misalign_expected", 32'(misalign_err), 32'(e.misal));
            chk("misalign_stall", 32'(mem_stall), 32'd0);
            chk("misalign_req", 32'(dm_req), 32'd0);
          end
        end
        if (dm_req && !req_prev) begin
          if (exp_q.size() == 0) fail("req_unexpected");
          else begin
            e = exp_q[0];
            chk("req_addr", dm_addr, e.addr);
            chk("req_web", 32'(dm_web), 32'(e.web));
            if (e.is_st) chk("req_wdata", dm_wdata, e.wdata);
          end
        end
        if (mem_stall) begin
          if (stall_cnt > 0) chk("req_held", 32'(dm_req), 32'd1);
          stall_cnt++;
        end else if (stall_cnt > 0) begin
          if (exp_q.size() == 0) fail("done_unexpected");
          else begin
            e = exp_q.pop_front();
            chk("done_kind", 32'(e.misal), 32'd0);
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
            chk("dm_out", DM_OUT, e.out);
            chk("done_req", 32'(dm_req), 32'd0);
          end
          stall_cnt = 0;
        end else if (timeout_err) begin
          fail("timeout_spurious");
        end
        req_prev = dm_req;
      end
    end
  end

  // Drives one instruction at the current negedge and returns at the next issue point.
  task automatic issue(input logic v, input logic [2:0] ld, input logic [1:0] st,
                       input logic [31:0] a, input logic [31:0] d, input int lat,
                       input bit junk);
    exp_t        e;
    bit          is_ld, is_st;
    int          sz, off, busy, base;
    logic [31:0] w;
    is_ld = (ld >= 3'd1) && (ld <= 3'd5);
    is_st = !is_ld && (st != 2'd0);
    mem_valid    = v;
    is_load_mem  = ld;
    is_store_mem = st;
    alu_out_mem  = a;
    rs2_data_mem = d;
    if (!(v && (is_ld || is_st))) begin
      @(negedge clk);
      return;
    end
    if (is_ld) sz = (ld == 3'd1 || ld == 3'd4) ? 1 : (ld == 3'd3) ? 4 : 2;
    else       sz = (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : 4;
    off   = int'(a % 4);
    base  = int'(a % 64) - off;
    e.misal = (a % sz) != 0;
    e.tmo   = 1'b0;
    e.is_st = is_st;
    e.stall = 0;
    e.out   = '0;
    e.addr  = a & 32'hFFFF_FFFC;
    e.web   = '0;
    e.wdata = '0;
    if (e.misal) begin
      exp_q.push_back(e);
      @(negedge clk);
      return;
    end
    if (is_st)
      for (int k = 0; k < 4; k++) begin
        e.wdata[8*k +: 8] = d[8*(k % sz) +: 8];
        if (k >= off && k < off + sz) e.web[k] = 1'b1;
      end
    busy    = (lat < int'(TMO)) ? lat + 1 : int'(TMO);
    e.stall = 1 + busy;
    e.tmo   = lat >= int'(TMO);
    if (e.tmo) last_out = '0;
    else if (is_ld) begin
      w = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
      last_out = w >> (8 * off);
    end else begin
      for (int i = 0; i < sz; i++) ref_mem[base + off + i] = d[8*i +: 8];
    end
    e.out = last_out;
    exp_q.push_back(e);
    lat_q.push_back(lat);
    repeat (busy + 1) @(negedge clk);
    if (junk) begin
      mem_valid    = 1'b1;
      is_load_mem  = 3'($urandom_range(0, 7));
      is_store_mem = 2'($urandom_range(0, 3));
      alu_out_mem  = $urandom();
      rs2_data_mem = $urandom();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = (i == 0) ? 32'h80FF_1234 : $urandom();
      dev_mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    last_out     = '0;
    rst          = 1'b0;
    mem_valid    = 1'b0;
    is_load_mem  = '0;
    is_store_mem = '0;
    alu_out_mem  = '0;
    rs2_data_mem = '0;

    #12;
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_dm_web", 32'(dm_web), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_dm_out", DM_OUT, 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_stall", 32'(mem_stall), 32'd0);
    chk("idle_req", 32'(dm_req), 32'd0);

    // Reset in the middle of an outstanding access.
    mem_valid   = 1'b1;
    is_load_mem = 3'd3;
    alu_out_mem = 32'h0000_0040;
    @(negedge clk);
    #1;
    chk("busy_req", 32'(dm_req), 32'd1);
    #1;
    rst       = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("midrst_req", 32'(dm_req), 32'd0);
    chk("midrst_stall", 32'(mem_stall), 32'd0);
    chk("midrst_addr", dm_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_stall", 32'(mem_stall), 32'd0);
    chk("post_rst_req", 32'(dm_req), 32'd0);

    @(negedge clk);
    mem_en = 1'b1;
    mon_en = 1'b1;
    issue(1'b1, 3'd1, 2'd0, 32'h0000_1003, 32'h0, 0, 1'b0);
    issue(1'b1, 3'd0, 2'd2, 32'h0000_2002, 32'h0000_ABCD, 3, 1'b0);
    issue(1'b1, 3'd3, 2'd0, 32'h0000_3001, 32'h0, 0, 1'b0);
    issue(1'b1, 3'd3, 2'd0, 32'h0000_4000, 32'h0, 10, 1'b0);
    w = $urandom();
    issue(1'b1, 3'd0, 2'd3, 32'h0000_0010, w, 0, 1'b0);
    issue(1'b1, 3'd3, 2'd0, 32'h0000_0010, 32'h0, 0, 1'b0);
    issue(1'b1, 3'd2, 2'd3, 32'h0000_0012, $urandom(), 1, 1'b1);

    for (int n = 0; n < 400; n++) begin
      issue(1'($urandom_range(0, 9) != 0),
            3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)),
            {$urandom_range(0, 255) << 6} | 32'($urandom_range(0, 63)),
            $urandom(),
            $urandom_range(0, 5),
            1'($urandom_range(0, 1)));
    end

    mem_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
